// File: rtl/bip_pkg.sv
// Shared definitions for the accumulator-machine sequencer: field widths,
// opcodes, FSM states and accumulator source codes.
package bip_pkg;

  localparam int BIP_PC_W  = 11;
  localparam int BIP_OPR_W = 11;
  localparam int BIP_OPC_W = 5;

  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: instruction class flags plus the datapath
// controls that depend only on the opcode.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opc,
  output logic       is_mem_read,
  output logic       is_store,
  output logic       is_imm,
  output logic       is_halt,
  output logic       alu_op,
  output logic [1:0] sel_a_code
);

  // Opcode table; unlisted opcodes fall through as NOP (all flags low).
  always_comb begin
    is_mem_read = 1'b0;
    is_store    = 1'b0;
    is_imm      = 1'b0;
    is_halt     = 1'b0;
    alu_op      = 1'b0;
    sel_a_code  = SELA_MEM;
    case (opc)
      OP_HLT:  is_halt = 1'b1;
      OP_STO:  is_store = 1'b1;
      OP_LD:   is_mem_read = 1'b1;
      OP_LDI:  begin is_imm = 1'b1; sel_a_code = SELA_IMM; end
      OP_ADD:  begin is_mem_read = 1'b1; alu_op = 1'b1; sel_a_code = SELA_ALU; end
      OP_ADDI: begin is_imm = 1'b1; alu_op = 1'b1; sel_a_code = SELA_ALU; end
      OP_SUB:  begin is_mem_read = 1'b1; sel_a_code = SELA_ALU; end
      OP_SUBI: begin is_imm = 1'b1; sel_a_code = SELA_ALU; end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_sequencer.sv
// Multi-cycle control unit: fetches from a 1-cycle-latency ROM, decodes,
// and drives data-RAM strobes, accumulator load and ALU/mux selects.
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int PC_W  = BIP_PC_W,
  parameter int OPR_W = BIP_OPR_W,
  parameter int OPC_W = BIP_OPC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [PC_W-1:0]        instr_addr,
  input  logic [OPC_W+OPR_W-1:0] instr_data,
  output logic [OPR_W-1:0]       data_addr,
  output logic                   data_rd,
  output logic                   data_wr,
  output logic [OPR_W-1:0]       operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   alu_op,
  output logic                   acc_wr,
  output logic                   busy,
  output logic                   halted
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t                   state, state_nxt;
  logic [PC_W-1:0]          pc, pc_nxt;
  logic [OPC_W+OPR_W-1:0]   ir;
  logic                     armed;

  logic       is_mem_read, is_store, is_imm, is_halt, dec_alu_op;
  logic [1:0] sel_a_code;

  bip_decoder u_dec (
    .opc         (ir[OPC_W+OPR_W-1 -: 5]),
    .is_mem_read (is_mem_read),
    .is_store    (is_store),
    .is_imm      (is_imm),
    .is_halt     (is_halt),
    .alu_op      (dec_alu_op),
    .sel_a_code  (sel_a_code)
  );

  // State, PC and IR registers; armed blocks a start sampled on the first
  // edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      armed <= 1'b1;
      if (state == S_FETCH) ir <= instr_data;
    end
  end

  // Next-state and next-PC logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE:  if (start && armed) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_halt)          state_nxt = S_HALT;
        else if (is_mem_read) state_nxt = S_WB;
        else begin
          state_nxt = S_FETCH;
          pc_nxt    = pc + PC_ONE;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + PC_ONE;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs of state+IR. The ROM address looks one step ahead
  // (pc_nxt) so the word for the upcoming FETCH is already on instr_data
  // when FETCH is entered; in IDLE/FETCH/HALT this equals PC.
  always_comb begin
    instr_addr = pc_nxt;
    operand    = ir[OPR_W-1:0];
    data_addr  = ir[OPR_W-1:0];
    data_rd    = (state == S_EXEC) && is_mem_read;
    data_wr    = (state == S_EXEC) && is_store;
    acc_wr     = ((state == S_EXEC) && is_imm) || (state == S_WB);
    sel_a      = acc_wr ? sel_a_code : SELA_MEM;
    sel_b      = (state == S_EXEC) && is_imm;
    alu_op     = acc_wr && dec_alu_op;
    busy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_WB);
    halted     = (state == S_HALT);
  end

endmodule

// File: tb/tb_bip_sequencer.sv
// Scoreboard bench: an instruction-level model walks the ROM image and
// queues expected strobe events and fetch addresses with cycle stamps; a
// monitor on the falling edge pops and compares what the DUT presents.
module tb_bip_sequencer;
  import bip_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [10:0] instr_addr, data_addr, operand;
  logic [15:0] instr_data;
  logic        data_rd, data_wr, sel_b, alu_op, acc_wr, busy, halted;
  logic [1:0]  sel_a;

  bip_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr_addr(instr_addr),
    .instr_data(instr_data), .data_addr(data_addr), .data_rd(data_rd),
    .data_wr(data_wr), .operand(operand), .sel_a(sel_a), .sel_b(sel_b),
    .alu_op(alu_op), .acc_wr(acc_wr), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:2047];
  always @(posedge clk) instr_data <= rom[instr_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // kind: 0 = data_rd, 1 = data_wr, 2 = acc_wr
  typedef struct { int t; int kind; int addr; int sa; int sb; int op; } ev_t;
  typedef struct { int t; int pc; } fe_t;
  ev_t evq[$];
  fe_t feq[$];
  int  total = 0, bad = 0;
  bit  mon_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ins(logic [4:0] opc, logic [10:0] opr);
    return {opc, opr};
  endfunction

  // Instruction-level reference: instruction k executes at t, non-read
  // instructions take 2 cycles, RAM-read instructions 3; FETCH is t-1.
  task automatic build_expect(int s, int max_instr, output int halt_t, output int halt_pc);
    int pc = 0;
    int t  = s + 1;
    halt_t = -1; halt_pc = -1;
    for (int k = 0; k < max_instr; k++) begin
      logic [15:0] w;
      int opc, opr;
      w = rom[pc]; opc = int'(w[15:11]); opr = int'(w[10:0]);
      feq.push_back('{t - 1, pc});
      case (opc)
        0: begin halt_t = t + 1; halt_pc = pc; return; end
        1: evq.push_back('{t, 1, opr, 0, 0, 0});
        2: begin evq.push_back('{t, 0, opr, 0, 0, 0}); evq.push_back('{t + 1, 2, opr, 0, 0, 0}); end
        3: evq.push_back('{t, 2, opr, 1, 1, 0});
        4: begin evq.push_back('{t, 0, opr, 0, 0, 0}); evq.push_back('{t + 1, 2, opr, 2, 0, 1}); end
        5: evq.push_back('{t, 2, opr, 2, 1, 1});
        6: begin evq.push_back('{t, 0, opr, 0, 0, 0}); evq.push_back('{t + 1, 2, opr, 2, 0, 0}); end
        7: evq.push_back('{t, 2, opr, 2, 1, 0});
        default: ;
      endcase
      t += (opc == 2 || opc == 4 || opc == 6) ? 3 : 2;
      pc = (pc + 1) % 2048;
    end
  endtask

  // Monitor: compare strobes and fetch addresses against the queues.
  always @(negedge clk) begin
    ev_t e;
    fe_t f;
    if (mon_en) begin
      if (data_rd || data_wr || acc_wr) begin
        chk("strobe_onehot", int'(data_rd) + int'(data_wr) + int'(acc_wr), 1);
        if (evq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe rd=%0b wr=%0b acc=%0b want none (cyc %0d)",
                   data_rd, data_wr, acc_wr, cyc);
        end else begin
          e = evq.pop_front();
          chk("ev_cycle", cyc, e.t);
          chk("ev_kind", data_rd ? 0 : (data_wr ? 1 : 2), e.kind);
          chk("data_addr", 32'(data_addr), e.addr);
          if (e.kind == 2) begin
            chk("sel_a", 32'(sel_a), e.sa);
            chk("sel_b", 32'(sel_b), e.sb);
            chk("alu_op", 32'(alu_op), e.op);
            chk("operand", 32'(operand), e.addr);
          end
        end
      end else if (evq.size() > 0 && evq[0].t < cyc) begin
        e = evq.pop_front();
        total++; bad++;
        $display("FAIL missing_strobe kind=%0d got none want at cyc %0d", e.kind, e.t);
      end
      if (feq.size() > 0 && feq[0].t <= cyc) begin
        f = feq.pop_front();
        chk("fetch_cycle", cyc, f.t);
        chk("fetch_addr", 32'(instr_addr), f.pc);
        chk("fetch_busy", 32'(busy), 1);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    mon_en = 1'b0; reset = 1'b0; start = 1'b0;
    evq.delete(); feq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic launch(int max_instr, output int ht, output int hp);
    build_expect(cyc + 1, max_instr, ht, hp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_halt(int ht, int hp);
    int n = 0;
    while (!halted && n < 400) begin @(negedge clk); n++; end
    chk("halt_cycle", cyc, ht);
    chk("halt_pc", 32'(instr_addr), hp);
    chk("halt_busy", 32'(busy), 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_pc_sticky", 32'(instr_addr), hp);
    chk("evq_drained", evq.size(), 0);
    chk("feq_drained", feq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ht, hp, n, len;
    clear_rom();
    // Reset state, held then released with no start.
    #1;
    chk("rst_strobes", 32'({data_rd, data_wr, acc_wr}), 0);
    chk("rst_sel", 32'({sel_a, sel_b, alu_op}), 0);
    chk("rst_busy_halted", 32'({busy, halted}), 0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("idle_strobes", 32'({data_rd, data_wr, acc_wr}), 0);
      chk("idle_busy_halted", 32'({busy, halted}), 0);
      chk("idle_addr", 32'(instr_addr), 0);
      @(negedge clk);
    end

    // LDI 5; ADDI 3; STO 0x010; HLT
    rom[0] = ins(5'd3, 11'd5); rom[1] = ins(5'd5, 11'd3);
    rom[2] = ins(5'd1, 11'h010); rom[3] = ins(5'd0, 11'd0);
    do_reset(); launch(10, ht, hp); finish_halt(ht, hp);

    // LD 0x020; SUB 0x021; HLT
    clear_rom();
    rom[0] = ins(5'd2, 11'h020); rom[1] = ins(5'd6, 11'h021);
    do_reset(); launch(10, ht, hp); finish_halt(ht, hp);

    // Unknown opcode acts as NOP.
    clear_rom();
    rom[0] = ins(5'd31, 11'h7AB);
    do_reset(); launch(10, ht, hp); finish_halt(ht, hp);

    // Start coincident with reset release is ignored.
    mon_en = 1'b0; reset = 1'b0; evq.delete(); feq.delete();
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rel_start_busy", 32'(busy), 0);
    @(negedge clk);
    chk("rel_start_busy2", 32'(busy), 0);

    // Reset asserted during WB of ADD.
    clear_rom();
    rom[0] = ins(5'd4, 11'h005);
    do_reset(); launch(10, ht, hp);
    n = 0;
    while (!acc_wr && n < 20) begin @(negedge clk); n++; end
    chk("wb_reached", 32'(acc_wr), 1);
    #1 reset = 1'b0; mon_en = 1'b0;
    #1;
    chk("abort_acc_wr", 32'(acc_wr), 0);
    chk("abort_strobes", 32'({data_rd, data_wr}), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", 32'(instr_addr), 0);
    evq.delete(); feq.delete();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_busy", 32'({busy, halted}), 0);
    chk("post_abort_pc", 32'(instr_addr), 0);

    // PC wrap over a ROM full of NOPs; a stray start mid-run is ignored.
    for (int i = 0; i < 2048; i++) rom[i] = ins(5'($urandom_range(8, 31)), 11'($urandom));
    do_reset(); launch(2052, ht, hp);
    repeat (100) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while ((feq.size() > 0 || evq.size() > 0) && n < 4300) begin @(negedge clk); n++; end
    chk("wrap_drained", feq.size() + evq.size(), 0);
    chk("wrap_busy", 32'(busy), 1);

    // Random programs terminated by HLT.
    for (int p = 0; p < 8; p++) begin
      clear_rom();
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        logic [4:0] opc;
        opc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
        rom[i] = ins(opc, 11'($urandom));
      end
      do_reset(); launch(64, ht, hp); finish_halt(ht, hp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
